// File: rtl/pipeline_pkg.sv
// Shared widths, encodings and types for the pipelined core.
package pipeline_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 8;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_HOLD
  } fetch_state_t;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc: '0};

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry parking register for a fetched instruction while decode is stalled.
module fetch_hold_buf
  import pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               rel,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  output logic               hold_valid,
  output logic [INSTR_W-1:0] hold_instr,
  output logic [ADDR_W-1:0]  hold_pc
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      instr_q <= load_instr;
      pc_q    <= load_pc;
    end else if (rel) begin
      valid_q <= 1'b0;
    end
  end

  assign hold_valid = valid_q;
  assign hold_instr = instr_q;
  assign hold_pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, ready-based imem handshake and the IF/ID pipeline register.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_if,
  input  logic               stall_id,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc
);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pend_pc_q;
  logic              inflight_q;
  logic              discard_q;
  if_id_t            if_id_q;

  logic               accept;
  logic               hold_load;
  logic               hold_rel;
  logic               hold_valid;
  logic [INSTR_W-1:0] hold_instr;
  logic [ADDR_W-1:0]  hold_pc;

  // A started request stays asserted until ready, regardless of stall_if.
  assign imem_req  = (state_q == S_REQ) && (inflight_q || !stall_if);
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;

  always_comb begin
    hold_load = 1'b0;
    hold_rel  = 1'b0;
    if (!redirect_valid) begin
      hold_load = (state_q == S_REQ) && accept && !discard_q && stall_id;
      hold_rel  = (state_q == S_HOLD) && !stall_id;
    end
  end

  fetch_hold_buf u_hold_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (hold_load),
    .rel        (hold_rel),
    .clear      (redirect_valid),
    .load_instr (imem_rdata),
    .load_pc    (pc_q),
    .hold_valid (hold_valid),
    .hold_instr (hold_instr),
    .hold_pc    (hold_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      if_id_q    <= IF_ID_BUBBLE;
    end else begin
      if (imem_req) inflight_q <= !imem_ready;

      if (redirect_valid) begin
        state_q <= S_REQ;
        if_id_q <= IF_ID_BUBBLE;
        // An unfinished request must still complete; park the target until it does.
        if (imem_req && !imem_ready) begin
          discard_q <= 1'b1;
          pend_pc_q <= redirect_pc;
        end else begin
          discard_q <= 1'b0;
          pc_q      <= redirect_pc;
        end
      end else begin
        case (state_q)
          S_BOOT: state_q <= S_REQ;
          S_REQ: begin
            if (accept) begin
              if (discard_q) begin
                pc_q      <= pend_pc_q;
                discard_q <= 1'b0;
                if_id_q   <= IF_ID_BUBBLE;
              end else begin
                pc_q <= pc_q + ADDR_W'(1);
                if (!stall_id) begin
                  if_id_q <= '{valid: 1'b1, instr: imem_rdata, pc: pc_q};
                end else begin
                  state_q <= S_HOLD;
                end
              end
            end else if (!stall_id) begin
              if_id_q <= IF_ID_BUBBLE;
            end
          end
          S_HOLD: begin
            if (!stall_id) begin
              if_id_q <= '{valid: 1'b1, instr: hold_instr, pc: hold_pc};
              state_q <= S_REQ;
            end
          end
          default: state_q <= S_BOOT;
        endcase
      end
    end
  end

  assign if_id_valid = if_id_q.valid;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc    = if_id_q.pc;

  // Parking only ever happens from S_REQ, so hold_valid tracks S_HOLD exactly.
  logic unused_hold_valid;
  assign unused_hold_valid = hold_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a memory returning 0x10 + address.
module tb_fetch_stage;

  logic       clk;
  logic       rst_n;
  logic       stall_if;
  logic       stall_id;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_ready;
  logic       if_id_valid;
  logic [7:0] if_id_instr;
  logic [7:0] if_id_pc;

  int checks = 0;
  int fails  = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc)
  );

  assign imem_rdata = 8'h10 + imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; stall_if = 0; stall_id = 0; redirect_valid = 0; redirect_pc = 0;
    imem_ready = 1'b1;
    #3;
    checks++;
    if ({imem_req, if_id_valid, if_id_instr, if_id_pc} !== {1'b0, 1'b0, 8'h00, 8'h00}) begin
      fails++;
      $display("FAIL reset_outputs: got req=%b v=%b i=%h pc=%h, want 0 0 00 00",
               imem_req, if_id_valid, if_id_instr, if_id_pc);
    end
    #4 rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      fails++; $display("FAIL boot_no_req: got %b want 0", imem_req);
    end
    tick();
    checks++;
    if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL first_req: got req=%b addr=%h v=%b, want 1 00 0",
               imem_req, imem_addr, if_id_valid);
    end
  endtask

  task automatic test_stream;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b1, 8'h10 + 8'(k), 8'(k)}) begin
        fails++;
        $display("FAIL stream_%0d: got v=%b i=%h pc=%h, want 1 %h %h", k, if_id_valid,
                 if_id_instr, if_id_pc, 8'h10 + 8'(k), 8'(k));
      end
    end
  endtask

  task automatic test_stall_hold;
    stall_id = 1'b1;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h04}) begin
      fails++; $display("FAIL hold_accept_req: got %b %h want 1 04", imem_req, imem_addr);
    end
    tick();
    stall_if = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({imem_req, if_id_valid, if_id_instr, if_id_pc} !== {1'b0, 1'b1, 8'h13, 8'h03}) begin
        fails++;
        $display("FAIL hold_frozen_%0d: got req=%b v=%b i=%h pc=%h, want 0 1 13 03", k,
                 imem_req, if_id_valid, if_id_instr, if_id_pc);
      end
      if (k < 3) tick();
    end
    stall_if = 1'b0; stall_id = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      fails++; $display("FAIL hold_release_req: got %b want 0", imem_req);
    end
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, imem_addr} !== {1'b1, 8'h14, 8'h04, 8'h05}) begin
      fails++;
      $display("FAIL hold_release: got v=%b i=%h pc=%h addr=%h, want 1 14 04 05",
               if_id_valid, if_id_instr, if_id_pc, imem_addr);
    end
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b1, 8'h15, 8'h05}) begin
      fails++;
      $display("FAIL after_hold: got v=%b i=%h pc=%h, want 1 15 05",
               if_id_valid, if_id_instr, if_id_pc);
    end
  endtask

  task automatic test_mem_wait;
    tick();  // delivers pc 6, pc now 7
    imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 8'h07}) begin
        fails++; $display("FAIL wait_req_%0d: got %b %h want 1 07", k, imem_req, imem_addr);
      end
      tick();
      checks++;
      if (if_id_valid !== 1'b0) begin
        fails++; $display("FAIL wait_bubble_%0d: got v=%b want 0", k, if_id_valid);
      end
      if (k == 0) stall_if = 1'b1;
    end
    imem_ready = 1'b1;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h07}) begin
      fails++; $display("FAIL wait_final_req: got %b %h want 1 07", imem_req, imem_addr);
    end
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, imem_req} !== {1'b1, 8'h17, 8'h07, 1'b0}) begin
      fails++;
      $display("FAIL wait_deliver: got v=%b i=%h pc=%h req=%b, want 1 17 07 0",
               if_id_valid, if_id_instr, if_id_pc, imem_req);
    end
    tick();
    checks++;
    if ({if_id_valid, imem_addr} !== {1'b0, 8'h08}) begin
      fails++;
      $display("FAIL wait_once: got v=%b addr=%h, want 0 08", if_id_valid, imem_addr);
    end
    stall_if = 1'b0;
  endtask

  task automatic test_redirect;
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({if_id_valid, imem_addr} !== {1'b0, 8'h40}) begin
      fails++; $display("FAIL redirect_bubble: got v=%b addr=%h, want 0 40", if_id_valid, imem_addr);
    end
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b1, 8'h50, 8'h40}) begin
      fails++;
      $display("FAIL redirect_target: got v=%b i=%h pc=%h, want 1 50 40",
               if_id_valid, if_id_instr, if_id_pc);
    end
  endtask

  task automatic test_redirect_discard;
    redirect_valid = 1'b1; redirect_pc = 8'h09;
    tick();
    redirect_valid = 1'b0; imem_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 8'h20;
    tick();
    redirect_pc = 8'h30;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 8'h09, 1'b0}) begin
      fails++;
      $display("FAIL discard_wait: got req=%b addr=%h v=%b, want 1 09 0",
               imem_req, imem_addr, if_id_valid);
    end
    tick();
    imem_ready = 1'b1;
    tick();
    #1;
    checks++;
    if ({if_id_valid, imem_addr} !== {1'b0, 8'h30}) begin
      fails++;
      $display("FAIL discard_drop: got v=%b addr=%h, want 0 30", if_id_valid, imem_addr);
    end
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b1, 8'h40, 8'h30}) begin
      fails++;
      $display("FAIL discard_latest: got v=%b i=%h pc=%h, want 1 40 30",
               if_id_valid, if_id_instr, if_id_pc);
    end
  endtask

  task automatic test_redirect_hold_wrap;
    stall_id = 1'b1;
    tick();  // parks pc 0x31
    redirect_valid = 1'b1; redirect_pc = 8'hFF;
    tick();
    redirect_valid = 1'b0; stall_id = 1'b0;
    #1;
    checks++;
    if ({if_id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'hFF}) begin
      fails++;
      $display("FAIL hold_redirect: got v=%b req=%b addr=%h, want 0 1 ff",
               if_id_valid, imem_req, imem_addr);
    end
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, imem_addr} !== {1'b1, 8'h0F, 8'hFF, 8'h00}) begin
      fails++;
      $display("FAIL wrap_ff: got v=%b i=%h pc=%h addr=%h, want 1 0f ff 00",
               if_id_valid, if_id_instr, if_id_pc, imem_addr);
    end
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b1, 8'h10, 8'h00}) begin
      fails++;
      $display("FAIL wrap_00: got v=%b i=%h pc=%h, want 1 10 00",
               if_id_valid, if_id_instr, if_id_pc);
    end
  endtask

  task automatic test_async_reset;
    imem_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, if_id_valid, if_id_instr, if_id_pc, imem_addr} !==
        {1'b0, 1'b0, 8'h00, 8'h00, 8'h00}) begin
      fails++;
      $display("FAIL async_reset: got req=%b v=%b i=%h pc=%h addr=%h, want 0 0 00 00 00",
               imem_req, if_id_valid, if_id_instr, if_id_pc, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_mem_wait();
    test_redirect();
    test_redirect_discard();
    test_redirect_hold_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
